instr_decoder_pipe: RTL

- Parametrised, handshaked successor to the single-cycle instruction decoder.
- Accepts a stream of instruction words over valid/ready.
- Assembles two-word instructions (opcode word plus immediate word) internally with a small FSM, then emits one registered decoded-instruction bundle per instruction to the register-file/ALU stage.
- Supports pipeline flush on taken branches, and backpressure from the execute stage.

---
 rtl/instr_decoder_pipe_pkg.sv | 43 ++++
 rtl/instr_field_decode.sv | 62 ++++++
 rtl/instr_decoder_pipe.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/instr_decoder_pipe_pkg.sv
// Shared constants for the pipelined instruction decoder: opcode map, MOVB range,
// bundle field widths and the assembly FSM states.
package instr_decoder_pipe_pkg;

   localparam int OPC_W = 8;
   localparam int ALU_W = 8;
   localparam int PC_W  = 2;

   // Base opcodes have bit 7 clear; setting bit 7 selects the two-word form.
   localparam logic [OPC_W-1:0] OPC_NOP     = 8'h00;
   localparam logic [OPC_W-1:0] OPC_ADD     = 8'h01;
   localparam logic [OPC_W-1:0] OPC_SUB     = 8'h02;
   localparam logic [OPC_W-1:0] OPC_AND     = 8'h03;
   localparam logic [OPC_W-1:0] OPC_OR      = 8'h04;
   localparam logic [OPC_W-1:0] OPC_XOR     = 8'h05;
   localparam logic [OPC_W-1:0] OPC_MOV     = 8'h06;
   localparam logic [OPC_W-1:0] OPC_LD      = 8'h10;
   localparam logic [OPC_W-1:0] OPC_ST      = 8'h11;
   localparam logic [OPC_W-1:0] OPC_LDI     = 8'h12;
   localparam logic [OPC_W-1:0] OPC_STI     = 8'h13;
   localparam logic [OPC_W-1:0] OPC_PUSH    = 8'h14;
   localparam logic [OPC_W-1:0] OPC_POP     = 8'h15;
   localparam logic [OPC_W-1:0] OPC_PUSHLR  = 8'h17;
   localparam logic [OPC_W-1:0] OPC_JMP     = 8'h20;
   localparam logic [OPC_W-1:0] OPC_SET     = 8'h22;
   localparam logic [OPC_W-1:0] OPC_CALL    = 8'h23;
   localparam logic [OPC_W-1:0] OPC_SPEC    = 8'h30;
   localparam logic [OPC_W-1:0] OPC_PUSHI   = 8'h94;
   localparam logic [OPC_W-1:0] OPC_JMPI    = 8'hA0;
   localparam logic [OPC_W-1:0] OPC_CALLI   = 8'hA3;
   localparam logic [OPC_W-1:0] OPC_MOVB_R0 = 8'hF0;
   localparam logic [OPC_W-1:0] OPC_MOVB_R7 = 8'hF7;

   typedef enum logic {
      S_OPC = 1'b0,
      S_IMM = 1'b1
   } state_e;

   function automatic logic is_movb(input logic [OPC_W-1:0] opc);
      return (opc >= OPC_MOVB_R0) && (opc <= OPC_MOVB_R7);
   endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Combinational instruction-word to control-field decoder, used both for one-word
// bundles and for the pending half of a two-word instruction.
module instr_field_decode
   import instr_decoder_pipe_pkg::*;
#(
   parameter int                   WORD_W    = 16,
   parameter int                   REG_SEL_W = 3,
   parameter int                   COND_W    = 4,
   parameter logic [REG_SEL_W-1:0] SP_SEL    = '1
) (
   input  logic [WORD_W-1:0]    word,
   output logic [ALU_W-1:0]     alu_control,
   output logic [REG_SEL_W-1:0] rd_sel,
   output logic [REG_SEL_W-1:0] rs_sel,
   output logic [WORD_W-1:0]    immediate,
   output logic                 en_immediate,
   output logic                 en_mem,
   output logic                 mem_byte,
   output logic                 mem_displacement,
   output logic                 lr_is_input,
   output logic [COND_W-1:0]    condition,
   output logic                 needs_imm
);

   logic [OPC_W-1:0] opc;
   logic             movb;
   logic             is_ldst;
   logic             is_stack;
   logic             is_disp;
   logic             is_cond;

   always_comb begin
      opc      = word[WORD_W-1:WORD_W-OPC_W];
      movb     = is_movb(opc);
      is_ldst  = (opc == OPC_ST) || (opc == OPC_LD) || (opc == OPC_LDI) || (opc == OPC_STI);
      is_stack = (opc == OPC_PUSH) || (opc == OPC_POP) || (opc == OPC_PUSHI) || (opc == OPC_PUSHLR);
      is_disp  = (opc == OPC_LDI) || (opc == OPC_STI);
      is_cond  = (opc == OPC_JMP) || (opc == OPC_JMPI) || (opc == OPC_SET) ||
                 (opc == OPC_CALL) || (opc == OPC_CALLI);

      alu_control      = {1'b0, opc[OPC_W-2:0]};
      rd_sel           = word[REG_SEL_W-1:0];
      rs_sel           = is_stack ? SP_SEL : word[REG_SEL_W+2:3];
      immediate        = '0;
      en_immediate     = opc[OPC_W-1];
      en_mem           = is_ldst || is_stack;
      mem_byte         = is_ldst ? word[7] : 1'b0;
      mem_displacement = is_disp ? word[6] : 1'b0;
      lr_is_input      = (opc == OPC_SPEC) || (opc == OPC_PUSHLR);
      condition        = is_cond ? word[COND_W+2:3] : '0;
      needs_imm        = opc[OPC_W-1] && !movb;

      // MOVB carries its byte immediate inline and encodes rD in the opcode itself.
      if (movb) begin
         alu_control  = OPC_MOV;
         rd_sel       = REG_SEL_W'(opc - OPC_MOVB_R0);
         immediate    = {{(WORD_W-8){1'b0}}, word[7:0]};
         en_immediate = 1'b1;
      end
   end

endmodule

// File: rtl/instr_decoder_pipe.sv
// Handshaked instruction decoder: assembles one- and two-word instructions and
// emits one registered decoded bundle per instruction, with flush and backpressure.
module instr_decoder_pipe
   import instr_decoder_pipe_pkg::*;
#(
   parameter int                   WORD_W    = 16,
   parameter int                   REG_SEL_W = 3,
   parameter int                   COND_W    = 4,
   parameter logic [REG_SEL_W-1:0] SP_SEL    = '1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WORD_W-1:0]    instr_word,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ALU_W-1:0]     alu_control,
   output logic [REG_SEL_W-1:0] rD_sel,
   output logic [REG_SEL_W-1:0] rS_sel,
   output logic [WORD_W-1:0]    immediate,
   output logic                 en_immediate,
   output logic                 two_word,
   output logic                 en_mem,
   output logic                 mem_byte,
   output logic                 mem_displacement,
   output logic                 lr_is_input,
   output logic [COND_W-1:0]    condition,
   output logic [PC_W-1:0]      pc_words,
   output state_e               state_dbg
);

   typedef struct packed {
      logic [ALU_W-1:0]     alu_control;
      logic [REG_SEL_W-1:0] rd_sel;
      logic [REG_SEL_W-1:0] rs_sel;
      logic                 en_immediate;
      logic                 en_mem;
      logic                 mem_byte;
      logic                 mem_displacement;
      logic                 lr_is_input;
      logic [COND_W-1:0]    condition;
   } fields_t;

   typedef struct packed {
      fields_t             f;
      logic [WORD_W-1:0]   immediate;
      logic                two_word;
      logic [PC_W-1:0]     pc_words;
   } bundle_t;

   // Handshake: a word transfers on in_valid && in_ready; a bundle retires on
   // out_valid && out_ready. in_ready = !flush && (!out_valid || out_ready).
   state_e            state_q, state_d;
   logic              out_valid_q, out_valid_d;
   bundle_t           bundle_q, bundle_d;
   fields_t           pend_q, pend_d;
   fields_t           dec_f;
   logic [WORD_W-1:0] dec_imm;
   logic              dec_needs_imm;
   logic              xfer;

   instr_field_decode #(
      .WORD_W    (WORD_W),
      .REG_SEL_W (REG_SEL_W),
      .COND_W    (COND_W),
      .SP_SEL    (SP_SEL)
   ) u_field_decode (
      .word             (instr_word),
      .alu_control      (dec_f.alu_control),
      .rd_sel           (dec_f.rd_sel),
      .rs_sel           (dec_f.rs_sel),
      .immediate        (dec_imm),
      .en_immediate     (dec_f.en_immediate),
      .en_mem           (dec_f.en_mem),
      .mem_byte         (dec_f.mem_byte),
      .mem_displacement (dec_f.mem_displacement),
      .lr_is_input      (dec_f.lr_is_input),
      .condition        (dec_f.condition),
      .needs_imm        (dec_needs_imm)
   );

   assign in_ready = !flush && (!out_valid_q || out_ready);
   assign xfer     = in_valid && in_ready;

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q && !out_ready;
      bundle_d    = bundle_q;
      pend_d      = pend_q;

      if (flush) begin
         state_d     = S_OPC;
         out_valid_d = 1'b0;
      end else if (xfer) begin
         case (state_q)
            S_OPC: begin
               if (dec_needs_imm) begin
                  pend_d  = dec_f;
                  state_d = S_IMM;
               end else begin
                  bundle_d.f         = dec_f;
                  bundle_d.immediate = dec_imm;
                  bundle_d.two_word  = 1'b0;
                  bundle_d.pc_words  = PC_W'(1);
                  out_valid_d        = 1'b1;
               end
            end
            S_IMM: begin
               bundle_d.f         = pend_q;
               bundle_d.immediate = instr_word;
               bundle_d.two_word  = 1'b1;
               bundle_d.pc_words  = PC_W'(2);
               out_valid_d        = 1'b1;
               state_d            = S_OPC;
            end
            default: state_d = S_OPC;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_OPC;
         out_valid_q <= 1'b0;
         bundle_q    <= '0;
         pend_q      <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         bundle_q    <= bundle_d;
         pend_q      <= pend_d;
      end
   end

   assign out_valid        = out_valid_q;
   assign alu_control      = bundle_q.f.alu_control;
   assign rD_sel           = bundle_q.f.rd_sel;
   assign rS_sel           = bundle_q.f.rs_sel;
   assign immediate        = bundle_q.immediate;
   assign en_immediate     = bundle_q.f.en_immediate;
   assign two_word         = bundle_q.two_word;
   assign en_mem           = bundle_q.f.en_mem;
   assign mem_byte         = bundle_q.f.mem_byte;
   assign mem_displacement = bundle_q.f.mem_displacement;
   assign lr_is_input      = bundle_q.f.lr_is_input;
   assign condition        = bundle_q.f.condition;
   assign pc_words         = bundle_q.pc_words;
   assign state_dbg        = state_q;

endmodule
